// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit width and seven-segment pattern constants
package bcd_pkg;

  localparam int BCD_DIGIT_WIDTH = 4;
  localparam int SEG_WIDTH       = 7;

  typedef logic [BCD_DIGIT_WIDTH-1:0] bcd_digit_t;
  typedef logic [SEG_WIDTH-1:0]       seg_t;

  // Segment patterns, active high, bit order gfedcba
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// rtl/bcd_to_seven_segment.sv - combinational nibble to seven-segment decoder
module bcd_to_seven_segment
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_WIDTH-1:0] nibble,
  output logic [SEG_WIDTH-1:0]       segments,
  output logic                       invalid
);

  // Map 0-9 to digit glyphs; anything above 9 shows "E" and flags invalid
  always_comb begin
    invalid = 1'b0;
    case (nibble)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: begin
        segments = SEG_E;
        invalid  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed BCD seven-segment display scanner
module bcd_display_scanner
  import bcd_pkg::*;
#(
  parameter int NUMBER_DIGITS = 4,
  parameter int SCAN_DIVIDER  = 1000
)
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [BCD_DIGIT_WIDTH*NUMBER_DIGITS-1:0] bcd,
  input  logic [NUMBER_DIGITS-1:0]             dots,
  input  logic                                 load,
  input  logic                                 blank_leading_zeros,
  input  logic                                 enable,
  output logic [SEG_WIDTH-1:0]                 segments,
  output logic                                 dot,
  output logic [NUMBER_DIGITS-1:0]             digit_select,
  output logic                                 invalid_digit,
  output logic                                 frame
);

  localparam int BCD_WIDTH   = BCD_DIGIT_WIDTH * NUMBER_DIGITS;
  localparam int DIV_WIDTH   = (SCAN_DIVIDER > 2) ? $clog2(SCAN_DIVIDER) : 1;
  localparam int INDEX_WIDTH = (NUMBER_DIGITS > 1) ? $clog2(NUMBER_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0]   DIV_LAST   = DIV_WIDTH'(SCAN_DIVIDER - 1);
  localparam logic [INDEX_WIDTH-1:0] INDEX_LAST = INDEX_WIDTH'(NUMBER_DIGITS - 1);

  logic [BCD_WIDTH-1:0]     captured_bcd;
  logic [NUMBER_DIGITS-1:0] captured_dots;
  logic                     captured_blank;
  logic [DIV_WIDTH-1:0]     div_count;
  logic [INDEX_WIDTH-1:0]   digit_index;
  logic                     wrap_seen;

  logic [NUMBER_DIGITS-1:0]   leading_zero;
  logic                       zero_run;
  logic [BCD_DIGIT_WIDTH-1:0] selected_nibble;
  logic                       selected_dot;
  logic                       selected_blank;
  logic [NUMBER_DIGITS-1:0]   select_onehot;
  logic [SEG_WIDTH-1:0]       decoded_segments;
  logic                       decoded_invalid;
  logic                       div_wrap;
  logic                       index_wrap;

  assign div_wrap   = enable && (div_count == DIV_LAST);
  assign index_wrap = div_wrap && (digit_index == INDEX_LAST);

  // Digit i is a leading zero when it and every more significant nibble are zero
  always_comb begin
    zero_run     = 1'b1;
    leading_zero = '0;
    for (int i = NUMBER_DIGITS - 1; i >= 0; i--) begin
      zero_run        = zero_run && (captured_bcd[i*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] == '0);
      leading_zero[i] = zero_run;
    end
  end

  // Pick the nibble, dot and blank decision for the current scan index
  always_comb begin
    selected_nibble = '0;
    selected_dot    = 1'b0;
    selected_blank  = 1'b0;
    select_onehot   = '0;
    for (int i = 0; i < NUMBER_DIGITS; i++) begin
      if (digit_index == INDEX_WIDTH'(i)) begin
        selected_nibble  = captured_bcd[i*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH];
        selected_dot     = captured_dots[i];
        selected_blank   = captured_blank && (i > 0) && leading_zero[i];
        select_onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_seven_segment u_decoder (
    .nibble   (selected_nibble),
    .segments (decoded_segments),
    .invalid  (decoded_invalid)
  );

  // Capture registers, scan counters and registered display outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_bcd   <= '0;
      captured_dots  <= '0;
      captured_blank <= 1'b0;
      div_count      <= '0;
      digit_index    <= '0;
      wrap_seen      <= 1'b0;
      segments       <= SEG_BLANK;
      dot            <= 1'b0;
      digit_select   <= '0;
      invalid_digit  <= 1'b0;
      frame          <= 1'b0;
    end else begin
      if (load) begin
        captured_bcd   <= bcd;
        captured_dots  <= dots;
        captured_blank <= blank_leading_zeros;
      end

      if (enable) begin
        div_count <= div_wrap ? '0 : div_count + 1'b1;
      end
      if (div_wrap) begin
        digit_index <= index_wrap ? '0 : digit_index + 1'b1;
      end

      // The wrap is flagged on the edge the index returns to 0, so the
      // pulse lands on the same edge digit 0 first appears on the outputs
      wrap_seen <= index_wrap;
      frame     <= wrap_seen;

      if (enable) begin
        segments      <= selected_blank ? SEG_BLANK : decoded_segments;
        dot           <= selected_dot;
        digit_select  <= select_onehot;
        invalid_digit <= decoded_invalid;
      end else begin
        segments      <= SEG_BLANK;
        dot           <= 1'b0;
        digit_select  <= '0;
        invalid_digit <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter NUMBER_DIGITS, default 4, meaning the count of BCD digits captured and scanned; legal values are at least 1.
REQ-002 SHALL have parameter SCAN_DIVIDER, default 1000, meaning the clock cycles each digit is displayed; legal values are at least 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port bcd, input, 4*NUMBER_DIGITS bits: packed BCD value; digit 0 is in the least significant nibble.
REQ-006 SHALL have port dots, input, NUMBER_DIGITS bits: per-digit decimal point, bit i for digit i.
REQ-007 SHALL have port load, input, 1 bit: capture bcd and dots on this edge.
REQ-008 SHALL have port blank_leading_zeros, input, 1 bit: leading-zero suppression enable, sampled with load.
REQ-009 SHALL have port enable, input, 1 bit: scan enable; when low, all digits are dark and scanning is frozen.
REQ-010 SHALL have port segments, output, 7 bits: active-high segments, bit order gfedcba.
REQ-011 SHALL have port dot, output, 1 bit: active-high decimal point of the selected digit.
REQ-012 SHALL have port digit_select, output, NUMBER_DIGITS bits: one-hot active-high digit enable.
REQ-013 SHALL have port invalid_digit, output, 1 bit: high while the selected captured nibble is greater than 9.
REQ-014 SHALL have port frame, output, 1 bit: single-cycle pulse when the scan wraps from the last digit to digit 0.

Function
REQ-015 SHALL hold captured bcd, dots and blank flag in registers updated only on clock edges where load=1.
REQ-016 SHALL compute outputs registered from the captured registers; a load at edge t is visible on segments at edge t+1.
REQ-017 SHALL use a divider counter 0..SCAN_DIVIDER-1, incrementing when enable=1 and wrapping to 0.
REQ-018 SHALL advance the digit index on the wrap edge of the divider: from i to i+1, and from NUMBER_DIGITS-1 to 0.
REQ-019 SHALL assert frame for exactly one cycle, registered with the outputs, when the index wraps from NUMBER_DIGITS-1 to 0.
REQ-020 SHALL drive digit_select as one-hot of the index when enable=1, and as all zeros when enable=0.
REQ-021 SHALL keep the divider and index values while enable=0; scanning resumes from them when enable returns high.
REQ-022 SHALL decode nibbles 0-9 to standard seven-segment patterns (0=0111111, 1=0000110, 8=1111111).
REQ-023 SHALL display nibbles 10-15 as the "E" pattern (1111001) and assert invalid_digit.
REQ-024 SHALL, when the blank flag is set, blank digit i (segments=0) if nibble i and all higher nibbles equal 0.
REQ-025 SHALL never blank digit 0, and SHALL still drive the dot of a blanked digit from dots.
REQ-026 SHALL, when load coincides with an index advance, decode the new index using the newly captured data.

Reset
REQ-027 SHALL, on reset=1, clear captured bcd, dots and blank flag to 0, and clear the divider and index to 0.
REQ-028 SHALL, on reset=1, drive segments=0, dot=0, digit_select=0, invalid_digit=0 and frame=0 on the following edge.
REQ-029 SHALL give reset priority over load and enable; a reset in mid-scan restarts at digit 0 with a full divider period.

Structure
REQ-030 SHALL place BCD_DIGIT_WIDTH=4 and the seven-segment pattern constants, including the "E" pattern, in shared package bcd_pkg.
REQ-031 SHALL instantiate one combinational sub-module, bcd_to_seven_segment, mapping a 4-bit nibble to segments and an invalid flag.

Verification
REQ-032 SHALL cover this case: NUMBER_DIGITS=4, SCAN_DIVIDER=4, load bcd=0x1234, enable=1 -> digit_select cycles 0001,0010,0100,1000 every 4 cycles with segments for 4,3,2,1; frame pulses once per 16 cycles.
REQ-033 SHALL cover this case: load bcd=0x0070 with blank_leading_zeros=1 -> digits 3 and 2 blank, digit 1 shows 7, digit 0 shows 0.
REQ-034 SHALL cover this case: load bcd=0x0000 with blank_leading_zeros=1 -> only digit 0 lit, showing 0111111.
REQ-035 SHALL cover this case: load bcd=0x00A5 -> digit 1 shows 1111001 with invalid_digit=1; other digits have invalid_digit=0.
REQ-036 SHALL cover this case: enable low for 10 cycles in mid-digit -> digit_select=0 and counters frozen; after re-enable, the same digit completes its remaining cycles.
REQ-037 SHALL cover this case: reset asserted together with load of 0x9999 mid-scan -> all outputs 0 on the next edge, and captured data remains 0.
